// File: rtl/dfp128_norm_iter.sv
// Iterative DFP128 post-add normalizer: one optional carry right-shift, then
// bounded left shifts of up to SHIFT_DIGITS BCD digits per cycle.
module dfp128_norm_iter #(
    parameter int          SHIFT_DIGITS = 4,
    parameter logic [13:0] EMAX         = 14'h2FFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic         i_sign,
    input  logic [13:0]  i_exp,
    input  logic [279:0] i_sig,
    input  logic         i_nan,
    input  logic         i_qnan,
    input  logic         i_snan,
    input  logic         i_inf,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_sign,
    output logic [13:0]  o_exp,
    output logic [135:0] o_sig,
    output logic [3:0]   o_rnd,
    output logic         o_sticky,
    output logic         o_nan,
    output logic         o_qnan,
    output logic         o_snan,
    output logic         o_inf,
    output logic         o_zero
);
    typedef enum logic [1:0] {IDLE, RSH, SHIFT, DONE} state_t;
    localparam logic [6:0] SD = 7'(SHIFT_DIGITS);

    state_t         r_state;
    logic [283:0]   r_w;
    logic [14:0]    r_e;
    logic           r_s;
    logic           r_i_ready, r_o_valid, r_sign, r_sticky;
    logic           r_nan, r_qnan, r_snan, r_inf, r_zero;
    logic [13:0]    r_exp;
    logic [135:0]   r_sig;
    logic [3:0]     r_rnd;

    logic [6:0]     w_lz, w_k;
    logic           w_found, w_allz, w_exit, w_ovf;
    logic [283:0]   w_wsh;
    logic [14:0]    w_esh;

    // Leading-zero digit count from D68 down; 69 means the significand is zero.
    always_comb begin
        w_lz    = 7'd69;
        w_found = 1'b0;
        for (int i = 68; i >= 0; i--) begin
            if (!w_found && r_w[4*i +: 4] != 4'h0) begin
                w_lz    = 7'(68 - i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_k = (w_lz < SD) ? w_lz : SD;
        if (r_e < {8'd0, w_k})
            w_k = r_e[6:0];
        w_wsh  = r_w << {w_k, 2'b00};
        w_esh  = r_e - {8'd0, w_k};
        w_allz = (r_w[279:0] == 280'd0);
        // Exit is judged on the post-shift word so the last shift is not wasted.
        w_exit = w_allz || (w_esh == 15'd0) || (w_wsh[275:272] != 4'h0);
        w_ovf  = (w_esh >= {1'b0, EMAX});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_w       <= '0;
            r_e       <= '0;
            r_s       <= 1'b0;
            r_i_ready <= 1'b1;
            r_o_valid <= 1'b0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_sig     <= '0;
            r_rnd     <= '0;
            r_sticky  <= 1'b0;
            r_nan     <= 1'b0;
            r_qnan    <= 1'b0;
            r_snan    <= 1'b0;
            r_inf     <= 1'b0;
            r_zero    <= 1'b0;
        end else if (ce) begin
            case (r_state)
                IDLE: if (i_valid) begin
                    r_w       <= {4'h0, i_sig};
                    r_e       <= {1'b0, i_exp};
                    r_s       <= 1'b0;
                    r_i_ready <= 1'b0;
                    r_sign    <= i_sign;
                    if (i_nan || i_qnan || i_snan || i_inf) begin
                        r_exp     <= i_exp;
                        r_sig     <= i_sig[275:140];
                        r_rnd     <= i_sig[139:136];
                        r_sticky  <= |i_sig[135:0];
                        r_nan     <= i_nan;
                        r_qnan    <= i_qnan;
                        r_snan    <= i_snan;
                        r_inf     <= i_inf;
                        r_zero    <= 1'b0;
                        r_o_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state <= RSH;
                    end
                end
                RSH: begin
                    if (r_w[279:276] != 4'h0) begin
                        r_w <= r_w >> 4;
                        r_s <= r_s | (r_w[3:0] != 4'h0);
                        r_e <= r_e + 15'd1;
                    end
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_w <= w_wsh;
                    r_e <= w_allz ? 15'd0 : w_esh;
                    if (w_exit) begin
                        r_nan     <= 1'b0;
                        r_qnan    <= 1'b0;
                        r_snan    <= 1'b0;
                        r_zero    <= w_allz;
                        r_inf     <= !w_allz && w_ovf;
                        if (w_allz || w_ovf) begin
                            r_exp    <= w_allz ? 14'd0 : EMAX;
                            r_sig    <= '0;
                            r_rnd    <= '0;
                            r_sticky <= 1'b0;
                        end else begin
                            r_exp    <= w_esh[13:0];
                            r_sig    <= w_wsh[275:140];
                            r_rnd    <= w_wsh[139:136];
                            r_sticky <= r_s | (|w_wsh[135:0]);
                        end
                        r_o_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: if (o_ready) begin
                    r_o_valid <= 1'b0;
                    r_i_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_ready  = r_i_ready;
    assign o_valid  = r_o_valid;
    assign o_sign   = r_sign;
    assign o_exp    = r_exp;
    assign o_sig    = r_sig;
    assign o_rnd    = r_rnd;
    assign o_sticky = r_sticky;
    assign o_nan    = r_nan;
    assign o_qnan   = r_qnan;
    assign o_snan   = r_snan;
    assign o_inf    = r_inf;
    assign o_zero   = r_zero;
endmodule
